// File: rtl/svf_cfg_arbiter_pkg.sv
// Shared types for the SVF configuration-write arbiter.
//   svf_cfg_state_e : arbiter FSM states (IDLE / ISSUE / WAIT_ACK)
//   svf_cfg_req_t   : one path/key/value write at the default field widths
package svf_cfg_pkg;

    localparam int PATH_W_DEF = 8;
    localparam int KEY_W_DEF  = 8;
    localparam int VAL_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } svf_cfg_state_e;

    typedef struct packed {
        logic [PATH_W_DEF-1:0] path;
        logic [KEY_W_DEF-1:0]  key;
        logic [VAL_W_DEF-1:0]  val;
    } svf_cfg_req_t;

endpackage

// File: rtl/svf_cfg_arbiter_if.sv
// Bundle of requester-side and sink-side signals of the configuration arbiter.
//   master : the arbiter's view (drives grants, responses and the cfg_* write)
//   slave  : the environment's view (requesters plus configuration sink)
// Requester i occupies slice i of the packed req_path/req_key/req_val buses.
interface svf_cfg_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int PATH_W = 8,
    parameter int KEY_W  = 8,
    parameter int VAL_W  = 32
);
    localparam int SW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*PATH_W-1:0] req_path;
    logic [N_REQ*KEY_W-1:0]  req_key;
    logic [N_REQ*VAL_W-1:0]  req_val;
    logic [N_REQ-1:0]        rsp_done;
    logic [N_REQ-1:0]        rsp_err;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [PATH_W-1:0]       cfg_path;
    logic [KEY_W-1:0]        cfg_key;
    logic [VAL_W-1:0]        cfg_val;
    logic [SW-1:0]           cfg_src;
    logic                    cfg_ack;
    logic                    busy;

    modport master (
        input  req_valid, req_path, req_key, req_val, cfg_ready, cfg_ack,
        output req_ready, rsp_done, rsp_err, cfg_valid, cfg_path, cfg_key,
               cfg_val, cfg_src, busy
    );

    modport slave (
        output req_valid, req_path, req_key, req_val, cfg_ready, cfg_ack,
        input  req_ready, rsp_done, rsp_err, cfg_valid, cfg_path, cfg_key,
               cfg_val, cfg_src, busy
    );

endinterface

// File: rtl/svf_cfg_arbiter_rr_arb.sv
// Combinational round-robin picker.
//   req     : request vector
//   last    : index of the most recently served requester
//   gnt     : one-hot grant, first set bit searching upward from last+1 (wrapping)
//   gnt_idx : binary index of the granted requester
//   any     : at least one request present
// The request vector is rotated so that position 0 corresponds to last+1,
// a prefix-OR picks the lowest set bit, and the result is rotated back.
module svf_rr_arb #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    logic [SW:0]   shift;
    logic [N-1:0]  req_rot;
    logic [N-1:0]  sel_rot;
    logic [N-1:0]  lower;
    logic [SW-1:0] idx_acc [N+1];

    // last+1 can equal N, hence the extra bit
    assign shift   = {1'b0, last} + (SW+1)'(1);
    assign req_rot = N'({req, req} >> shift);

    assign lower[0]   = 1'b0;
    assign idx_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pick
            if (gi > 0) begin : g_lower
                assign lower[gi] = lower[gi-1] | req_rot[gi-1];
            end
            assign sel_rot[gi]    = req_rot[gi] & ~lower[gi];
            assign idx_acc[gi+1]  = idx_acc[gi] | (gnt[gi] ? SW'(gi) : '0);
        end
    endgenerate

    assign gnt     = N'(({sel_rot, sel_rot} << shift) >> N);
    assign gnt_idx = idx_acc[N];
    assign any     = |req;

endmodule

// File: rtl/svf_cfg_arbiter.sv
// Round-robin arbiter sharing one configuration-write channel between N_REQ
// requesters. A granted (path, key, value) write is latched, offered to the
// sink until accepted, then the block waits for the sink's completion ack or
// a timeout and pulses rsp_done / rsp_err to the owner.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : requester and sink signals (svf_cfg_arbiter_if.master)
// N_REQ must be 2..16, TIMEOUT_CYC must be >= 2.
module svf_cfg_arbiter
    import svf_cfg_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int PATH_W      = 8,
    parameter int KEY_W       = 8,
    parameter int VAL_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    svf_cfg_arbiter_if.master bus
);

    localparam int SW    = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    svf_cfg_state_e    state_reg;
    logic [SW-1:0]     last_reg;
    logic [SW-1:0]     src_reg;
    logic [N_REQ-1:0]  owner_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [PATH_W-1:0] path_reg;
    logic [KEY_W-1:0]  key_reg;
    logic [VAL_W-1:0]  val_reg;
    logic              cfg_valid_reg;
    logic              busy_reg;
    logic [N_REQ-1:0]  rsp_done_reg;
    logic [N_REQ-1:0]  rsp_err_reg;

    logic [PATH_W-1:0] path_arr [N_REQ];
    logic [KEY_W-1:0]  key_arr  [N_REQ];
    logic [VAL_W-1:0]  val_arr  [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign path_arr[gi] = bus.req_path[gi*PATH_W +: PATH_W];
            assign key_arr[gi]  = bus.req_key[gi*KEY_W +: KEY_W];
            assign val_arr[gi]  = bus.req_val[gi*VAL_W +: VAL_W];
        end
    endgenerate

    logic [N_REQ-1:0] gnt;
    logic [SW-1:0]    gnt_idx;
    logic             any_req;

    svf_rr_arb #(.N(N_REQ)) u_arb (
        .req     (bus.req_valid),
        .last    (last_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    // Grant is only offered while idle; acceptance is valid & ready on the edge.
    assign bus.req_ready = (state_reg == IDLE) ? gnt : '0;

    assign bus.cfg_valid = cfg_valid_reg;
    assign bus.cfg_path  = path_reg;
    assign bus.cfg_key   = key_reg;
    assign bus.cfg_val   = val_reg;
    assign bus.cfg_src   = src_reg;
    assign bus.busy      = busy_reg;
    assign bus.rsp_done  = rsp_done_reg;
    assign bus.rsp_err   = rsp_err_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            last_reg      <= SW'(N_REQ - 1);
            src_reg       <= '0;
            owner_reg     <= '0;
            cnt_reg       <= '0;
            path_reg      <= '0;
            key_reg       <= '0;
            val_reg       <= '0;
            cfg_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            rsp_done_reg  <= '0;
            rsp_err_reg   <= '0;
        end else begin
            rsp_done_reg <= '0;
            rsp_err_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        path_reg      <= path_arr[gnt_idx];
                        key_reg       <= key_arr[gnt_idx];
                        val_reg       <= val_arr[gnt_idx];
                        src_reg       <= gnt_idx;
                        owner_reg     <= gnt;
                        cfg_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.cfg_ready) begin
                        cfg_valid_reg <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (bus.cfg_ack) begin
                        rsp_done_reg <= owner_reg;
                        last_reg     <= src_reg;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end else if (cnt_reg == CNT_MAX) begin
                        rsp_err_reg  <= owner_reg;
                        last_reg     <= src_reg;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    cfg_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/svf_cfg_arbiter.md
# svf_cfg_arbiter

Shares one configuration-write channel between `N_REQ` hardware requesters. Each requester presents a (path, key, value) configuration write, and the block grants one at a time in round-robin order. It drives the write onto a single sink port and waits for the sink's completion acknowledge, then returns a done or error pulse to the granted requester. The block sits between on-chip agents and the SVF configuration sink, the hardware-side counterpart of the `set_config_string` path/key/value service.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be 2..16.
- `PATH_W`, 8: width of the path identifier.
- `KEY_W`, 8: width of the key identifier.
- `VAL_W`, 32: width of the value.
- `TIMEOUT_CYC`, 1024: maximum cycles spent in WAIT_ACK before the write is abandoned; must be ≥ 2.

Ports (`SW = $clog2(N_REQ)`):
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rstn`, in, 1: reset, asynchronous assert, active-low.
- `req_valid`, in, N_REQ: per-requester write request.
- `req_ready`, out, N_REQ: one-hot grant; the request is accepted on the edge where valid and ready are both high.
- `req_path`, in, N_REQ*PATH_W: packed request paths; requester i uses slice i.
- `req_key`, in, N_REQ*KEY_W: packed request keys.
- `req_val`, in, N_REQ*VAL_W: packed request values.
- `rsp_done`, out, N_REQ: one-cycle pulse to the owner when its write completed.
- `rsp_err`, out, N_REQ: one-cycle pulse to the owner when its write timed out.
- `cfg_valid`, out, 1: write offered to the sink.
- `cfg_ready`, in, 1: sink accepts the write.
- `cfg_path`, out, PATH_W: latched path of the write.
- `cfg_key`, out, KEY_W: latched key of the write.
- `cfg_val`, out, VAL_W: latched value of the write.
- `cfg_src`, out, SW: index of the current owner.
- `cfg_ack`, in, 1: sink completion pulse.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_ACK.
- **IDLE:**
  - If any `req_valid` is high, the arbiter picks the winner g: the first set bit searching upward from `last+1`, wrapping.
  - `req_ready[g]` is driven combinationally in that cycle only.
  - On the edge, the block latches path, key, value and `cfg_src=g`, then goes to ISSUE.
- **ISSUE:**
  - `cfg_valid` is held at 1.
  - On `cfg_ready`, the block goes to WAIT_ACK and clears the timeout counter.
- **WAIT_ACK:**
  - `cfg_valid` is 0 and the counter increments every cycle.
  - On `cfg_ack`: pulse `rsp_done[g]`, set `last<=g`, return to IDLE.
  - Otherwise, when the counter reaches `TIMEOUT_CYC-1`: pulse `rsp_err[g]`, set `last<=g`, return to IDLE.
  - If `cfg_ack` arrives in that same cycle, ack wins and no error is raised.
- `cfg_ack` is ignored in IDLE and ISSUE.
- `req_ready` is all-zero outside IDLE. Requesters hold valid and data until accepted.
- `req_valid` dropped before acceptance loses nothing; the requester is simply not granted.
- The `cfg_*` data outputs are stable from the ISSUE entry edge until the next acceptance.
- Round-robin pointer `last`:
  - Updates only on completion or error.
  - A single requester that is continuously valid is granted back-to-back.
  - With all requesters valid, the grant order starting from reset is 0, 1, 2, …, N_REQ-1, 0, ….

## Timing
- Reset values:
  - State IDLE, `last = N_REQ-1`, counter 0.
  - `cfg_valid`, `rsp_done`, `rsp_err`, `busy` all 0.
  - `cfg_path`, `cfg_key`, `cfg_val`, `cfg_src` all 0.
  - `req_ready` is 0 unless a request is pending in IDLE after reset deasserts.
- Latency, with acceptance at edge 0:
  - `cfg_valid` is high in cycle 1.
  - With `cfg_ready=1` in cycle 1, the state is WAIT_ACK in cycle 2.
  - With `cfg_ack` in cycle 2, `rsp_done` is high in cycle 3 and the next grant is possible in cycle 3.
- Peak throughput is one write per 3 cycles.
- Timeout:
  - `rsp_err` pulses in the cycle after TIMEOUT_CYC cycles have elapsed in WAIT_ACK.
  - The state is IDLE in that same cycle.
- The `rsp_*` pulses are registered, last exactly one cycle and are mutually exclusive.
- Reset asserted mid-transaction returns all state to reset values immediately. No done or error is issued for the lost write.

## Structure
- Package `svf_cfg_pkg` holds:
  - the `svf_cfg_state_e` enum (IDLE/ISSUE/WAIT_ACK);
  - a typedef struct `svf_cfg_req_t` with path/key/val fields, parameterised by the package's default widths.
- Sub-module `svf_rr_arb`: a purely combinational round-robin picker.
  - Inputs: `req[N]`, `last[SW]`.
  - Outputs: `gnt[N]` one-hot, `gnt_idx[SW]`, `any`.
  - It is reused by other SVF arbiters.
- The top level holds the FSM, latches and timeout counter.

## Test plan
- Single write: requester 2 sends path=0x11, key=0x22, val=0xDEADBEEF, and the sink gives ready plus ack immediately. Expect:
  - the `cfg_*` outputs carry those values with `cfg_src=2`;
  - `rsp_done[2]` in cycle 3;
  - `busy` high for exactly cycles 1–2.
- Fairness: all 4 requesters continuously valid for 8 writes. Expect grant order 0,1,2,3,0,1,2,3 and no `rsp_err`.
- Backpressure: `cfg_ready` held low for 5 cycles. Expect:
  - `cfg_valid` and the data stable throughout;
  - `req_ready` all-zero;
  - completion only after `cfg_ready` is seen.
- Timeout: `TIMEOUT_CYC=8` and the sink never acks. Expect `rsp_err[g]` exactly 8 cycles after WAIT_ACK entry, then the next requester granted.
- Ack/timeout tie: `cfg_ack` on the timeout cycle. Expect `rsp_done` pulses and `rsp_err` stays 0.
- Reset mid-WAIT_ACK: drop `rstn` for 1 cycle. Expect all outputs at reset values, no response pulse, and requester 0 granted first afterward.
